mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage between the execute stage and the write-back stage of the five-stage MIPS core. It accepts the execute-stage bus, waits for the data-SRAM response of any load/store issued on its entry, and buffers that response if write-back stalls. It aligns and extends load data (LWL/LWR merge masks included) and drops responses belonging to flushed instructions. It also drives the hazard/forward buses and the exception/EntryHi back-pressure signals used upstream.

## Interface
- ES_TO_MS_BUS_WD, 140, input bus width.
- MS_TO_WS_BUS_WD, 130, output bus width.
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high.
- flush  in  1  exception/ERET flush from write-back; kills the held instruction.
- ws_allowin  in  1  write-back can accept.
- ms_allowin  out  1  this stage can accept.
- es_to_ms_valid  in  1  execute stage offers an instruction.
- es_to_ms_bus  in  140  [139]tlbr [138]tlbwi [137]tlbp [136:105]cp0_index_wdata [104]store_op [103]bd [102]exc [101:94]exc_type [93]eret [92]cp0_wen [91]res_from_cp0 [90:83]cp0_addr [82]res_from_mem [81:75]inst_load {lw,lb,lbu,lh,lhu,lwl,lwr} [74:70]ld_extd_op (ignored) [69]gr_we [68:64]dest [63:32]alu_result [31:0]pc.
- ms_to_ws_valid  out  1  offer to write-back.
- ms_to_ws_bus  out  130  {tlbr,tlbwi,tlbp,cp0_index_wdata[31:0],bd,exc,exc_type[7:0],eret,cp0_wen,res_from_cp0,cp0_addr[7:0],gr_we,rf_wmask[3:0],dest[4:0],final_result[31:0],pc[31:0]}.
- stall_ms_bus  out  10  {5{ms_valid&&gr_we}}, dest.
- forward_ms_bus  out  33  {fwd_valid, final_result}.
- ms_exc_eret  out  1  ms_valid && (exc || eret); one bit of the execute stage's exc/eret input.
- ms_entryhi_stall  out  1  ms_valid && (tlbr || (cp0_wen && cp0_addr==8'h50)).
- data_sram_data_ok  in  1  one response per issued request, in order.
- data_sram_rdata  in  32  response data.

## Operation
- mem_op = res_from_mem || store_op. An entry is accepted when es_to_ms_valid && ms_allowin. Every accepted mem_op entry owns exactly one outstanding response, including entries with exc set.
- Held-entry states: IDLE (no valid entry), WAIT (mem_op, response not yet received), READY (non-mem entry, or response received, either live via data_ok or held in buffer rdata_buf/buf_valid).
- ms_ready_go = !mem_op || buf_valid || (data_ok && discard_cnt==0). ms_allowin = !ms_valid || (ms_ready_go && ws_allowin). ms_to_ws_valid = ms_valid && ms_ready_go.
- Buffer: if data_ok is consumed by the held entry and ws_allowin=0, latch rdata and set buf_valid. Clear buf_valid on handoff to write-back or on flush.
- Discard counter (2 bits): +1 when flush hits an entry in WAIT. +1 when a mem_op entry is accepted in the same cycle flush is high; the entry is dropped, but its request was issued. A data_ok with discard_cnt>0 is dropped and decrements the counter. Increment and decrement in the same cycle net out. The counter never exceeds 2.
- Load alignment, with n = alu_result[1:0] and w = selected word:
  - lw: w, mask 1111.
  - lb/lbu: byte n, sign- or zero-extended, mask 1111.
  - lh/lhu: half n[1], sign- or zero-extended, mask 1111.
  - lwl: w << 8*(3-n), mask = top n+1 bytes.
  - lwr: w >> 8*n, mask = low 4-n bytes.
- Non-load or exc: final_result = alu_result, which carries BadVAddr for an address error. Mask is 1111.
- fwd_valid = ms_valid && ms_ready_go && gr_we && !res_from_cp0 && !lwl && !lwr.
- flush clears ms_valid the next cycle, regardless of ws_allowin.

## Timing
- Reset values: ms_valid=0, buf_valid=0, discard_cnt=0. Outputs: ms_allowin=1, ms_to_ws_valid=0, stall_ms_bus[9:5]=0, forward valid=0, ms_exc_eret=0, ms_entryhi_stall=0.
- A non-mem entry can leave the stage in the cycle after entry, giving 1-cycle throughput.
- A mem entry can leave in the same cycle data_ok arrives (combinational path from data_ok/rdata to ms_to_ws_valid/bus).
- Bus register loads only on accept; contents are don't-care while ms_valid=0.
- flush and data_ok in the same cycle: if discard_cnt==0 and the entry is in WAIT, the response belongs to the held entry. That entry dies with no counter increment.

## Test plan
- lb at alu_result=0x...01, rdata=0x1280FF34, ws_allowin=1 -> same-cycle ms_to_ws_valid, final_result=0xFFFFFFFF, rf_wmask=1111.
- lwl at n=1, rdata=0xAABBCCDD -> final_result=0xCCDD0000, rf_wmask=1100. lwr at n=1 -> 0x00AABBCC, mask 0111. fwd_valid=0 in both cases.
- data_ok with ws_allowin=0 for 3 cycles -> buf_valid=1, ms_allowin=0. When ws_allowin rises, the buffered data is forwarded and a following addu enters the next cycle.
- flush while lw in WAIT, new lw accepted 2 cycles later -> first data_ok (0xDEAD) dropped, discard_cnt 1->0. Second data_ok (0xBEEF) is delivered.
- Accept a mem_op in the same cycle as flush while another lw is in WAIT -> discard_cnt=2. The next two data_ok are dropped. Stage stays empty.
- mtc0 EntryHi (cp0_addr=0x50) held with ws_allowin=0 -> ms_entryhi_stall=1. A store with exc=1 still waits for its data_ok, and ms_exc_eret=1 while valid.

Source files
------------

// File: rtl/mem_stage.sv
// MIPS memory stage: holds one instruction until its data-SRAM response arrives, then aligns/extends load data for write-back.
// Mem ops leave in their data_ok cycle, others one cycle after entry; while write-back stalls the response is buffered and ms_allowin drops.
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 140,
  parameter int MS_TO_WS_BUS_WD = 130
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [9:0]                 stall_ms_bus,
  output logic [32:0]                forward_ms_bus,
  output logic                       ms_exc_eret,
  output logic                       ms_entryhi_stall,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata
);

  typedef struct packed {
    logic lw;
    logic lb;
    logic lbu;
    logic lh;
    logic lhu;
    logic lwl;
    logic lwr;
  } load_t;

  typedef struct packed {
    logic        tlbr;
    logic        tlbwi;
    logic        tlbp;
    logic [31:0] cp0_index_wdata;
    logic        store_op;
    logic        bd;
    logic        exc;
    logic [7:0]  exc_type;
    logic        eret;
    logic        cp0_wen;
    logic        res_from_cp0;
    logic [7:0]  cp0_addr;
    logic        res_from_mem;
    load_t       inst_load;
    logic [4:0]  ld_extd_op;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_bus_t;

  typedef struct packed {
    logic        tlbr;
    logic        tlbwi;
    logic        tlbp;
    logic [31:0] cp0_index_wdata;
    logic        bd;
    logic        exc;
    logic [7:0]  exc_type;
    logic        eret;
    logic        cp0_wen;
    logic        res_from_cp0;
    logic [7:0]  cp0_addr;
    logic        gr_we;
    logic [3:0]  rf_wmask;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } ws_bus_t;

  es_bus_t     es_bus;
  es_bus_t     ms_bus;
  ws_bus_t     ws_bus;
  logic        ms_valid;
  logic        buf_valid;
  logic [31:0] rdata_buf;
  logic [1:0]  discard_cnt;
  logic [1:0]  discard_cnt_nxt;

  logic        mem_op;
  logic        es_mem_op;
  logic        rsp_live;
  logic        ms_ready_go;
  logic        accept;
  logic        handoff;
  logic        wait_st;
  logic        discard_inc;
  logic        discard_dec;
  logic        buf_load;
  logic        fwd_valid;

  logic [31:0] ld_word;
  logic [1:0]  n;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] final_result;
  logic [3:0]  rf_wmask;
  logic        unused_ld_extd;

  assign es_bus    = es_to_ms_bus;
  assign mem_op    = ms_bus.res_from_mem || ms_bus.store_op;
  assign es_mem_op = es_bus.res_from_mem || es_bus.store_op;

  // A response only belongs to the held entry once every orphaned response has drained.
  assign rsp_live       = data_sram_data_ok && (discard_cnt == 2'd0);
  assign ms_ready_go    = !mem_op || buf_valid || rsp_live;
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go;
  assign accept         = es_to_ms_valid && ms_allowin;
  assign handoff        = ms_to_ws_valid && ws_allowin;
  assign wait_st        = ms_valid && mem_op && !buf_valid;
  assign buf_load       = wait_st && rsp_live && !ws_allowin && !flush;

  // Killing a waiting entry (whose response is not arriving now) or an entry accepted
  // under flush leaves one issued request whose response must be thrown away.
  assign discard_inc = flush && ((wait_st && !rsp_live) || (accept && es_mem_op));
  assign discard_dec = data_sram_data_ok && (discard_cnt != 2'd0);

  always_comb begin
    discard_cnt_nxt = discard_cnt;
    if (discard_inc && !discard_dec) begin
      discard_cnt_nxt = (discard_cnt == 2'd2) ? 2'd2 : discard_cnt + 2'd1;
    end else if (discard_dec && !discard_inc) begin
      discard_cnt_nxt = discard_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid    <= 1'b0;
      buf_valid   <= 1'b0;
      discard_cnt <= 2'd0;
    end else begin
      discard_cnt <= discard_cnt_nxt;
      if (flush) begin
        ms_valid <= 1'b0;
      end else if (ms_allowin) begin
        ms_valid <= es_to_ms_valid;
      end
      if (flush || handoff) begin
        buf_valid <= 1'b0;
      end else if (buf_load) begin
        buf_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      ms_bus <= es_bus;
    end
    if (buf_load) begin
      rdata_buf <= data_sram_rdata;
    end
  end

  assign ld_word  = buf_valid ? rdata_buf : data_sram_rdata;
  assign n        = ms_bus.alu_result[1:0];
  assign byte_sel = ld_word[{n, 3'b000} +: 8];
  assign half_sel = n[1] ? ld_word[31:16] : ld_word[15:0];

  // Faulting loads pass alu_result through untouched so write-back can report BadVAddr.
  always_comb begin
    final_result = ms_bus.alu_result;
    rf_wmask     = 4'b1111;
    if (ms_bus.res_from_mem && !ms_bus.exc) begin
      if (ms_bus.inst_load.lw) begin
        final_result = ld_word;
      end else if (ms_bus.inst_load.lb) begin
        final_result = {{24{byte_sel[7]}}, byte_sel};
      end else if (ms_bus.inst_load.lbu) begin
        final_result = {24'h0, byte_sel};
      end else if (ms_bus.inst_load.lh) begin
        final_result = {{16{half_sel[15]}}, half_sel};
      end else if (ms_bus.inst_load.lhu) begin
        final_result = {16'h0, half_sel};
      end else if (ms_bus.inst_load.lwl) begin
        final_result = ld_word << {2'd3 - n, 3'b000};
        rf_wmask     = 4'b1111 << (2'd3 - n);
      end else if (ms_bus.inst_load.lwr) begin
        final_result = ld_word >> {n, 3'b000};
        rf_wmask     = 4'b1111 >> n;
      end else begin
        final_result = ld_word;
      end
    end
  end

  assign fwd_valid = ms_valid && ms_ready_go && ms_bus.gr_we && !ms_bus.res_from_cp0
                     && !ms_bus.inst_load.lwl && !ms_bus.inst_load.lwr;

  always_comb begin
    ws_bus.tlbr            = ms_bus.tlbr;
    ws_bus.tlbwi           = ms_bus.tlbwi;
    ws_bus.tlbp            = ms_bus.tlbp;
    ws_bus.cp0_index_wdata = ms_bus.cp0_index_wdata;
    ws_bus.bd              = ms_bus.bd;
    ws_bus.exc             = ms_bus.exc;
    ws_bus.exc_type        = ms_bus.exc_type;
    ws_bus.eret            = ms_bus.eret;
    ws_bus.cp0_wen         = ms_bus.cp0_wen;
    ws_bus.res_from_cp0    = ms_bus.res_from_cp0;
    ws_bus.cp0_addr        = ms_bus.cp0_addr;
    ws_bus.gr_we           = ms_bus.gr_we;
    ws_bus.rf_wmask        = rf_wmask;
    ws_bus.dest            = ms_bus.dest;
    ws_bus.final_result    = final_result;
    ws_bus.pc              = ms_bus.pc;
  end

  assign ms_to_ws_bus     = ws_bus;
  assign forward_ms_bus   = {fwd_valid, final_result};
  assign stall_ms_bus     = {{5{ms_valid && ms_bus.gr_we}}, ms_bus.dest};
  assign ms_exc_eret      = ms_valid && (ms_bus.exc || ms_bus.eret);
  assign ms_entryhi_stall = ms_valid && (ms_bus.tlbr || (ms_bus.cp0_wen && ms_bus.cp0_addr == 8'h50));
  assign unused_ld_extd   = ^ms_bus.ld_extd_op;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized loads/stores/ALU ops
// compared against a byte-level reference model of MIPS load alignment.
module tb_mem_stage;

  localparam int K_LW = 0, K_LB = 1, K_LBU = 2, K_LH = 3, K_LHU = 4, K_LWL = 5, K_LWR = 6;
  localparam int K_ALU = 7, K_SW = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         ws_allowin;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [139:0] es_to_ms_bus;
  logic         ms_to_ws_valid;
  logic [129:0] ms_to_ws_bus;
  logic [9:0]   stall_ms_bus;
  logic [32:0]  forward_ms_bus;
  logic         ms_exc_eret;
  logic         ms_entryhi_stall;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;

  logic [31:0]  o_final;
  logic [31:0]  o_pc;
  logic [3:0]   o_mask;
  logic         o_exc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk               (clk),
    .reset             (reset),
    .flush             (flush),
    .ws_allowin        (ws_allowin),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .stall_ms_bus      (stall_ms_bus),
    .forward_ms_bus    (forward_ms_bus),
    .ms_exc_eret       (ms_exc_eret),
    .ms_entryhi_stall  (ms_entryhi_stall),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata)
  );

  assign o_final = ms_to_ws_bus[63:32];
  assign o_pc    = ms_to_ws_bus[31:0];
  assign o_mask  = ms_to_ws_bus[72:69];
  assign o_exc   = ms_to_ws_bus[93];

  function automatic logic [139:0] mk(input int kind, input logic exc, input logic cp0_wen,
                                      input logic [7:0] cp0_addr, input logic rfc0, input logic gw,
                                      input logic [4:0] dest, input logic [31:0] alu, input logic [31:0] pc);
    logic [6:0] ld;
    logic       st;
    ld = (kind <= K_LWR) ? (7'b1000000 >> kind) : 7'b0;
    st = (kind == K_SW);
    return {3'b000, 32'h0, st, 1'b0, exc, 8'h00, 1'b0, cp0_wen, rfc0, cp0_addr,
            |ld, ld, 5'b0, gw, dest, alu, pc};
  endfunction

  // Reference: treat the word as four bytes and place/extend them by value.
  function automatic void model(input int kind, input logic exc, input logic [31:0] alu,
                                input logic [31:0] w, output logic [31:0] res, output logic [3:0] mask);
    int n, v;
    logic [7:0] b [4];
    n = int'(alu[1:0]);
    for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
    res  = alu;
    mask = 4'hF;
    if (exc || kind > K_LWR) return;
    case (kind)
      K_LW: res = w;
      K_LB, K_LBU: begin
        v = int'(b[n]);
        if (kind == K_LB && v > 127) v -= 256;
        res = v;
      end
      K_LH, K_LHU: begin
        v = int'(b[2*(n/2)]) + 256 * int'(b[2*(n/2)+1]);
        if (kind == K_LH && v > 32767) v -= 65536;
        res = v;
      end
      K_LWL: begin
        res = 32'h0;
        for (int i = 0; i < 4; i++) begin
          if (i >= 3 - n) res[8*i +: 8] = b[i-3+n];
          else mask[i] = 1'b0;
        end
      end
      default: begin
        res = 32'h0;
        for (int i = 0; i < 4; i++) begin
          if (i <= 3 - n) res[8*i +: 8] = b[i+n];
          else mask[i] = 1'b0;
        end
      end
    endcase
  endfunction

  task automatic idle();
    flush = 1'b0; ws_allowin = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0;
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (ms_allowin !== 1'b1) begin n_fail++; $display("FAIL reset_allowin: got %b want 1", ms_allowin); end
    n_checks++; if (ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", ms_to_ws_valid); end
    n_checks++; if (stall_ms_bus[9:5] !== 5'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall_ms_bus[9:5]); end
    n_checks++; if (forward_ms_bus[32] !== 1'b0) begin n_fail++; $display("FAIL reset_fwd: got %b want 0", forward_ms_bus[32]); end
    n_checks++; if (ms_exc_eret !== 1'b0) begin n_fail++; $display("FAIL reset_exc_eret: got %b want 0", ms_exc_eret); end
    n_checks++; if (ms_entryhi_stall !== 1'b0) begin n_fail++; $display("FAIL reset_entryhi: got %b want 0", ms_entryhi_stall); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_lb();
    @(negedge clk); idle();
    es_to_ms_valid = 1'b1; es_to_ms_bus = mk(K_LB, 0, 0, 8'h0, 0, 1, 5'd9, 32'h0000_1001, 32'hBFC0_0100);
    @(negedge clk); es_to_ms_valid = 1'b0; #1;
    n_checks++; if ({ms_to_ws_valid, ms_allowin} !== 2'b00) begin n_fail++; $display("FAIL lb_wait: got valid/allowin %b want 00", {ms_to_ws_valid, ms_allowin}); end
    n_checks++; if (stall_ms_bus !== {5'b11111, 5'd9}) begin n_fail++; $display("FAIL lb_stall_bus: got %h want %h", stall_ms_bus, {5'b11111, 5'd9}); end
    @(negedge clk); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1280_FF34; #1;
    n_checks++; if ({ms_to_ws_valid, o_final, o_mask} !== {1'b1, 32'hFFFF_FFFF, 4'hF}) begin n_fail++; $display("FAIL lb_result: got %b %h %b want 1 ffffffff 1111", ms_to_ws_valid, o_final, o_mask); end
    n_checks++; if (forward_ms_bus !== {1'b1, 32'hFFFF_FFFF}) begin n_fail++; $display("FAIL lb_fwd: got %h want 1ffffffff", forward_ms_bus); end
    @(negedge clk); idle(); #1;
    n_checks++; if (ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL lb_drain: got %b want 0", ms_to_ws_valid); end
  endtask

  task automatic test_lwl_lwr();
    for (int t = 0; t < 2; t++) begin
      @(negedge clk); idle();
      es_to_ms_valid = 1'b1; es_to_ms_bus = mk(t == 0 ? K_LWL : K_LWR, 0, 0, 8'h0, 0, 1, 5'd4, 32'h0000_2001, 32'h100 + t);
      @(negedge clk); es_to_ms_valid = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hAABB_CCDD; #1;
      if (t == 0) begin
        n_checks++; if ({ms_to_ws_valid, o_final, o_mask, forward_ms_bus[32]} !== {1'b1, 32'hCCDD_0000, 4'b1100, 1'b0}) begin
          n_fail++; $display("FAIL lwl: got v=%b %h m=%b fwd=%b want 1 ccdd0000 1100 0", ms_to_ws_valid, o_final, o_mask, forward_ms_bus[32]); end
      end else begin
        n_checks++; if ({ms_to_ws_valid, o_final, o_mask, forward_ms_bus[32]} !== {1'b1, 32'h00AA_BBCC, 4'b0111, 1'b0}) begin
          n_fail++; $display("FAIL lwr: got v=%b %h m=%b fwd=%b want 1 00aabbcc 0111 0", ms_to_ws_valid, o_final, o_mask, forward_ms_bus[32]); end
      end
    end
    @(negedge clk); idle();
  endtask

  task automatic test_buffer();
    @(negedge clk); idle();
    es_to_ms_valid = 1'b1; es_to_ms_bus = mk(K_LW, 0, 0, 8'h0, 0, 1, 5'd7, 32'h0000_0100, 32'hA000_0000);
    @(negedge clk); es_to_ms_valid = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h600D_F00D; ws_allowin = 1'b0; #1;
    n_checks++; if ({ms_to_ws_valid, ms_allowin} !== 2'b10) begin n_fail++; $display("FAIL buf_first: got valid/allowin %b want 10", {ms_to_ws_valid, ms_allowin}); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); data_sram_data_ok = 1'b0; data_sram_rdata = 32'h1357_9BDF + k; #1;
      n_checks++; if ({ms_to_ws_valid, ms_allowin, o_final} !== {2'b10, 32'h600D_F00D}) begin
        n_fail++; $display("FAIL buf_hold: got v=%b a=%b %h want 1 0 600df00d", ms_to_ws_valid, ms_allowin, o_final); end
    end
    @(negedge clk); ws_allowin = 1'b1; es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(K_ALU, 0, 0, 8'h0, 0, 1, 5'd3, 32'h1234_5678, 32'hA000_0004); #1;
    n_checks++; if ({ms_to_ws_valid, ms_allowin, o_final, o_pc} !== {2'b11, 32'h600D_F00D, 32'hA000_0000}) begin
      n_fail++; $display("FAIL buf_release: got v=%b a=%b %h pc=%h want 1 1 600df00d a0000000", ms_to_ws_valid, ms_allowin, o_final, o_pc); end
    @(negedge clk); es_to_ms_valid = 1'b0; #1;
    n_checks++; if ({ms_to_ws_valid, o_pc, forward_ms_bus} !== {1'b1, 32'hA000_0004, 1'b1, 32'h1234_5678}) begin
      n_fail++; $display("FAIL buf_next_addu: got v=%b pc=%h fwd=%h want 1 a0000004 112345678", ms_to_ws_valid, o_pc, forward_ms_bus); end
    @(negedge clk); idle();
  endtask

  task automatic test_flush_discard();
    @(negedge clk); idle();
    es_to_ms_valid = 1'b1; es_to_ms_bus = mk(K_LW, 0, 0, 8'h0, 0, 1, 5'd2, 32'h0000_0040, 32'hB000_0000);
    @(negedge clk); es_to_ms_valid = 1'b0; flush = 1'b1;
    @(negedge clk); flush = 1'b0; #1;
    n_checks++; if ({ms_to_ws_valid, ms_allowin} !== 2'b01) begin n_fail++; $display("FAIL flush_empty: got valid/allowin %b want 01", {ms_to_ws_valid, ms_allowin}); end
    @(negedge clk);
    es_to_ms_valid = 1'b1; es_to_ms_bus = mk(K_LW, 0, 0, 8'h0, 0, 1, 5'd2, 32'h0000_0044, 32'hB000_0010);
    @(negedge clk); es_to_ms_valid = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0000_DEAD; #1;
    n_checks++; if (ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop_dead: got %b want 0", ms_to_ws_valid); end
    @(negedge clk); data_sram_rdata = 32'h0000_BEEF; #1;
    n_checks++; if ({ms_to_ws_valid, o_final, o_pc} !== {1'b1, 32'h0000_BEEF, 32'hB000_0010}) begin
      n_fail++; $display("FAIL flush_deliver_beef: got v=%b %h pc=%h want 1 0000beef b0000010", ms_to_ws_valid, o_final, o_pc); end
    // flush coinciding with the held entry's own response
    @(negedge clk); idle();
    es_to_ms_valid = 1'b1; es_to_ms_bus = mk(K_LW, 0, 0, 8'h0, 0, 1, 5'd2, 32'h0000_0048, 32'hB000_0020);
    @(negedge clk); es_to_ms_valid = 1'b0; flush = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1111;
    @(negedge clk); idle();
    es_to_ms_valid = 1'b1; es_to_ms_bus = mk(K_LW, 0, 0, 8'h0, 0, 1, 5'd2, 32'h0000_004C, 32'hB000_0030);
    @(negedge clk); es_to_ms_valid = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h2222; #1;
    n_checks++; if ({ms_to_ws_valid, o_final, o_pc} !== {1'b1, 32'h2222, 32'hB000_0030}) begin
      n_fail++; $display("FAIL flush_same_cycle: got v=%b %h pc=%h want 1 00002222 b0000030", ms_to_ws_valid, o_final, o_pc); end
    @(negedge clk); idle();
  endtask

  task automatic test_double_discard();
    @(negedge clk); idle();
    es_to_ms_valid = 1'b1; es_to_ms_bus = mk(K_LW, 0, 0, 8'h0, 0, 1, 5'd5, 32'h0000_0080, 32'hC000_0000);
    @(negedge clk); es_to_ms_valid = 1'b0; flush = 1'b1;
    @(negedge clk); es_to_ms_valid = 1'b1; es_to_ms_bus = mk(K_SW, 0, 0, 8'h0, 0, 0, 5'd0, 32'h0000_0084, 32'hC000_0004); #1;
    n_checks++; if (ms_allowin !== 1'b1) begin n_fail++; $display("FAIL dd_accept_under_flush: got %b want 1", ms_allowin); end
    @(negedge clk); flush = 1'b0;
    es_to_ms_bus = mk(K_LW, 0, 0, 8'h0, 0, 1, 5'd5, 32'h0000_0088, 32'hC000_0008); #1;
    n_checks++; if ({ms_to_ws_valid, ms_allowin} !== 2'b01) begin n_fail++; $display("FAIL dd_stage_empty: got valid/allowin %b want 01", {ms_to_ws_valid, ms_allowin}); end
    @(negedge clk); es_to_ms_valid = 1'b0; data_sram_data_ok = 1'b1;
    for (int k = 0; k < 2; k++) begin
      data_sram_rdata = 32'hD1 + k; #1;
      n_checks++; if (ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL dd_drop%0d: got %b want 0", k, ms_to_ws_valid); end
      @(negedge clk);
    end
    data_sram_rdata = 32'h600D; #1;
    n_checks++; if ({ms_to_ws_valid, o_final, o_pc} !== {1'b1, 32'h600D, 32'hC000_0008}) begin
      n_fail++; $display("FAIL dd_deliver: got v=%b %h pc=%h want 1 0000600d c0000008", ms_to_ws_valid, o_final, o_pc); end
    @(negedge clk); idle();
  endtask

  task automatic test_entryhi_exc();
    @(negedge clk); idle();
    es_to_ms_valid = 1'b1; es_to_ms_bus = mk(K_ALU, 0, 1, 8'h50, 0, 0, 5'd0, 32'h0000_00FF, 32'hD000_0000);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); es_to_ms_valid = 1'b0; ws_allowin = 1'b0; #1;
      n_checks++; if ({ms_entryhi_stall, ms_to_ws_valid, ms_allowin} !== 3'b110) begin
        n_fail++; $display("FAIL entryhi_hold%0d: got stall/valid/allowin %b want 110", k, {ms_entryhi_stall, ms_to_ws_valid, ms_allowin}); end
    end
    @(negedge clk); ws_allowin = 1'b1;
    @(negedge clk);
    es_to_ms_valid = 1'b1; es_to_ms_bus = mk(K_SW, 1, 0, 8'h0, 0, 0, 5'd0, 32'h0000_0003, 32'hD000_0008);
    @(negedge clk); es_to_ms_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_checks++; if ({ms_exc_eret, ms_to_ws_valid, ms_entryhi_stall} !== 3'b100) begin
        n_fail++; $display("FAIL exc_store_wait%0d: got exc_eret/valid/entryhi %b want 100", k, {ms_exc_eret, ms_to_ws_valid, ms_entryhi_stall}); end
      @(negedge clk);
    end
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hFFFF_0000; #1;
    n_checks++; if ({ms_to_ws_valid, ms_exc_eret, o_exc, o_final, o_mask} !== {3'b111, 32'h0000_0003, 4'hF}) begin
      n_fail++; $display("FAIL exc_store_done: got v=%b ee=%b exc=%b %h m=%b want 1 1 1 00000003 1111", ms_to_ws_valid, ms_exc_eret, o_exc, o_final, o_mask); end
    @(negedge clk); idle(); #1;
    n_checks++; if (ms_exc_eret !== 1'b0) begin n_fail++; $display("FAIL exc_eret_clear: got %b want 0", ms_exc_eret); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] alus [8];
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); idle();
      alus[i] = $urandom;
      es_to_ms_valid = 1'b1; es_to_ms_bus = mk(K_ALU, 0, 0, 8'h0, 0, 1, 5'(i + 1), alus[i], 32'h0000_1000 + 4 * i); #1;
      if (i > 0) begin
        n_checks++; if ({ms_to_ws_valid, ms_allowin, o_pc, o_final} !== {2'b11, 32'h0000_1000 + 4 * (i - 1), alus[i-1]}) begin
          n_fail++; $display("FAIL b2b_%0d: got v=%b a=%b pc=%h %h want 1 1 %h %h", i, ms_to_ws_valid, ms_allowin, o_pc, o_final, 32'h0000_1000 + 4 * (i - 1), alus[i-1]); end
      end
    end
    @(negedge clk); idle(); #1;
    n_checks++; if ({ms_to_ws_valid, o_pc, o_final} !== {1'b1, 32'h0000_101C, alus[7]}) begin
      n_fail++; $display("FAIL b2b_last: got v=%b pc=%h %h want 1 0000101c %h", ms_to_ws_valid, o_pc, o_final, alus[7]); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 80; it++) begin
      int          kind, lat, stl;
      logic        exc, gw, rfc0, exp_fwd;
      logic [4:0]  dest;
      logic [31:0] alu, w, pc, exp_res;
      logic [3:0]  exp_mask;
      kind = $urandom_range(0, 8);
      exc  = ($urandom_range(0, 7) == 0);
      gw   = 1'($urandom_range(0, 1));
      rfc0 = (kind == K_ALU) ? 1'($urandom_range(0, 1)) : 1'b0;
      dest = 5'($urandom);
      alu  = $urandom; w = $urandom; pc = $urandom;
      lat  = $urandom_range(0, 2);
      stl  = $urandom_range(0, 2);
      model(kind, exc, alu, w, exp_res, exp_mask);
      exp_fwd = gw && !rfc0 && kind != K_LWL && kind != K_LWR;
      @(negedge clk); idle();
      es_to_ms_valid = 1'b1; es_to_ms_bus = mk(kind, exc, 0, 8'h0, rfc0, gw, dest, alu, pc); #1;
      n_checks++; if (ms_allowin !== 1'b1) begin n_fail++; $display("FAIL rnd_accept it=%0d: got %b want 1", it, ms_allowin); end
      @(negedge clk); es_to_ms_valid = 1'b0;
      if (kind != K_ALU) begin
        for (int k = 0; k < lat; k++) begin
          #1;
          n_checks++; if (ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_wait it=%0d: got %b want 0", it, ms_to_ws_valid); end
          @(negedge clk);
        end
        data_sram_data_ok = 1'b1; data_sram_rdata = w;
      end
      for (int k = 0; k < stl; k++) begin
        ws_allowin = 1'b0; #1;
        n_checks++; if ({ms_to_ws_valid, ms_allowin, o_final} !== {2'b10, exp_res}) begin
          n_fail++; $display("FAIL rnd_stall it=%0d kind=%0d: got v=%b a=%b %h want 1 0 %h", it, kind, ms_to_ws_valid, ms_allowin, o_final, exp_res); end
        @(negedge clk); data_sram_data_ok = 1'b0; data_sram_rdata = $urandom;
      end
      ws_allowin = 1'b1; #1;
      n_checks++; if ({ms_to_ws_valid, o_final, o_mask, o_pc} !== {1'b1, exp_res, exp_mask, pc}) begin
        n_fail++; $display("FAIL rnd_result it=%0d kind=%0d exc=%b: got v=%b %h m=%b pc=%h want 1 %h %b %h", it, kind, exc, ms_to_ws_valid, o_final, o_mask, o_pc, exp_res, exp_mask, pc); end
      n_checks++; if ({forward_ms_bus[32], stall_ms_bus} !== {exp_fwd, {5{gw}}, dest}) begin
        n_fail++; $display("FAIL rnd_fwd_stall it=%0d: got fwd=%b stall=%b want %b %b", it, forward_ms_bus[32], stall_ms_bus, exp_fwd, {{5{gw}}, dest}); end
    end
    @(negedge clk); idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_lb();
    test_lwl_lwr();
    test_buffer();
    test_flush_discard();
    test_double_discard();
    test_entryhi_exc();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
